// File: rtl/alu_seq.sv
// Sequential ALU front end: 4x4 register file, one command at a time through
// IDLE -> ISSUE -> EXEC -> WB, with an external combinational ALU.
module alu_seq #(
  parameter bit LOGIC_CLR_C = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ld,
  input  logic       cmd_l,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_l,
  input  logic [3:0] alu_r,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_sign,
  output logic       done,
  output logic [3:0] res,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_s,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WB} state_e;

  state_e     state_q, state_d;
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];
  logic [1:0] rd_q, rd_d;
  logic       isLd_q, isLd_d;
  logic [3:0] wbData_q, wbData_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
  logic       sign_q, sign_d;
  logic [3:0] aluA_q, aluA_d;
  logic [3:0] aluB_q, aluB_d;
  logic [1:0] aluOp_q, aluOp_d;
  logic       aluL_q, aluL_d;
  logic [3:0] res_q, res_d;
  logic       flagZ_q, flagZ_d;
  logic       flagC_q, flagC_d;
  logic       flagS_q, flagS_d;
  logic       accept;

  // Reset overrides the IDLE state so no command slips in while held.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_ld ? WB : ISSUE;
      ISSUE:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loads park the immediate in wbData at acceptance; ALU ops overwrite it in EXEC.
  always_comb begin
    regs_d   = regs_q;
    rd_d     = rd_q;
    isLd_d   = isLd_q;
    wbData_d = wbData_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    sign_d   = sign_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluOp_d  = aluOp_q;
    aluL_d   = aluL_q;
    res_d    = res_q;
    flagZ_d  = flagZ_q;
    flagC_d  = flagC_q;
    flagS_d  = flagS_q;

    if (accept) begin
      rd_d   = cmd_rd;
      isLd_d = cmd_ld;
      if (cmd_ld) begin
        wbData_d = cmd_imm;
      end else begin
        aluA_d  = regs_q[cmd_ra];
        aluB_d  = regs_q[cmd_rb];
        aluOp_d = cmd_op;
        aluL_d  = cmd_l;
      end
    end

    if (state_q == EXEC) begin
      wbData_d = alu_r;
      zero_d   = alu_zero;
      carry_d  = alu_carry;
      sign_d   = alu_sign;
    end

    if (state_q == WB) begin
      regs_d[rd_q] = wbData_q;
      res_d        = wbData_q;
      if (!isLd_q) begin
        flagZ_d = zero_q;
        flagS_d = sign_q;
        if (!aluL_q) begin
          flagC_d = carry_q;
        end else if (LOGIC_CLR_C) begin
          flagC_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      rd_q     <= '0;
      isLd_q   <= 1'b0;
      wbData_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluOp_q  <= '0;
      aluL_q   <= 1'b0;
      res_q    <= '0;
      flagZ_q  <= 1'b0;
      flagC_q  <= 1'b0;
      flagS_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      rd_q     <= rd_d;
      isLd_q   <= isLd_d;
      wbData_q <= wbData_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluOp_q  <= aluOp_d;
      aluL_q   <= aluL_d;
      res_q    <= res_d;
      flagZ_q  <= flagZ_d;
      flagC_q  <= flagC_d;
      flagS_q  <= flagS_d;
    end
  end

  assign alu_a    = aluA_q;
  assign alu_b    = aluB_q;
  assign alu_op   = aluOp_q;
  assign alu_l    = aluL_q;
  assign done     = (state_q == WB);
  assign res      = res_q;
  assign flag_z   = flagZ_q;
  assign flag_c   = flagC_q;
  assign flag_s   = flagS_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: two instances (carry cleared / kept on logic ops)
// share stimulus and each gets its own behavioural ALU.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmdValid = 1'b0, cmdLd = 1'b0, cmdL = 1'b0;
  logic [1:0] cmdOp = '0, cmdRd = '0, cmdRa = '0, cmdRb = '0;
  logic [3:0] cmdImm = '0;
  logic [1:0] dbgAddr = '0;

  logic       cmdReady, aluL, aluZero, aluCarry, aluSign, done, flagZ, flagC, flagS;
  logic [3:0] aluA, aluB, aluR, res, dbgData;
  logic [1:0] aluOp;
  logic       kReady, kAluL, kZero, kCarry, kSign, kDone, kFlagZ, kFlagC, kFlagS;
  logic [3:0] kAluA, kAluB, kAluR, kRes, kDbgData;
  logic [1:0] kAluOp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         expCyc;
    logic       isAlu;
    logic [1:0] rd;
    logic [3:0] res, oldVal, a, b;
    logic       z, s, c1, c0;
  } sbEntry;

  sbEntry     sbQ[$];
  sbEntry     cur;
  bit         postPending = 0;
  logic [3:0] mRegs [4];
  logic       mZ, mS, mC1, mC0;

  // Arithmetic: add, sub, inc, dec with carry out; logic: and, or, xor, not with carry forced 1.
  function automatic logic [4:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op, input logic l);
    logic [4:0] r;
    if (!l) begin
      case (op)
        2'd0:    r = {1'b0, a} + {1'b0, b};
        2'd1:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
        2'd2:    r = {1'b0, a} + 5'd1;
        default: r = {1'b0, a} + 5'h0F;
      endcase
    end else begin
      case (op)
        2'd0:    r = {1'b1, a & b};
        2'd1:    r = {1'b1, a | b};
        2'd2:    r = {1'b1, a ^ b};
        default: r = {1'b1, ~a};
      endcase
    end
    return r;
  endfunction

  assign {aluCarry, aluR} = aluModel(aluA, aluB, aluOp, aluL);
  assign aluZero = (aluR == 4'd0);
  assign aluSign = aluR[3];
  assign {kCarry, kAluR} = aluModel(kAluA, kAluB, kAluOp, kAluL);
  assign kZero = (kAluR == 4'd0);
  assign kSign = kAluR[3];

  alu_seq #(.LOGIC_CLR_C(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_ld(cmdLd), .cmd_l(cmdL), .cmd_op(cmdOp), .cmd_rd(cmdRd), .cmd_ra(cmdRa),
    .cmd_rb(cmdRb), .cmd_imm(cmdImm), .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp),
    .alu_l(aluL), .alu_r(aluR), .alu_zero(aluZero), .alu_carry(aluCarry),
    .alu_sign(aluSign), .done(done), .res(res), .flag_z(flagZ), .flag_c(flagC),
    .flag_s(flagS), .dbg_addr(dbgAddr), .dbg_data(dbgData)
  );

  alu_seq #(.LOGIC_CLR_C(1'b0)) dutKeep (
    .clk(clk), .reset(reset), .cmd_valid(cmdValid), .cmd_ready(kReady),
    .cmd_ld(cmdLd), .cmd_l(cmdL), .cmd_op(cmdOp), .cmd_rd(cmdRd), .cmd_ra(cmdRa),
    .cmd_rb(cmdRb), .cmd_imm(cmdImm), .alu_a(kAluA), .alu_b(kAluB), .alu_op(kAluOp),
    .alu_l(kAluL), .alu_r(kAluR), .alu_zero(kZero), .alu_carry(kCarry),
    .alu_sign(kSign), .done(kDone), .res(kRes), .flag_z(kFlagZ), .flag_c(kFlagC),
    .flag_s(kFlagS), .dbg_addr(dbgAddr), .dbg_data(kDbgData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advances the reference model by one command and queues what writeback must show.
  task automatic pushExpected(input logic ld, input logic l, input logic [1:0] op,
                              input logic [1:0] rd, input logic [1:0] ra,
                              input logic [1:0] rb, input logic [3:0] imm);
    sbEntry     e;
    logic [4:0] cr;
    e.rd     = rd;
    e.oldVal = mRegs[rd];
    e.isAlu  = !ld;
    e.a      = mRegs[ra];
    e.b      = mRegs[rb];
    if (ld) begin
      e.res  = imm;
      e.expCyc = cyc + 1;
    end else begin
      cr     = aluModel(mRegs[ra], mRegs[rb], op, l);
      e.res  = cr[3:0];
      mZ     = (cr[3:0] == 4'd0);
      mS     = cr[3];
      if (!l) begin
        mC1 = cr[4];
        mC0 = cr[4];
      end else begin
        mC1 = 1'b0;
      end
      e.expCyc = cyc + 3;
    end
    mRegs[rd] = e.res;
    e.z  = mZ;
    e.s  = mS;
    e.c1 = mC1;
    e.c0 = mC0;
    sbQ.push_back(e);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 4; i++) mRegs[i] = 4'd0;
    mZ = 1'b0; mS = 1'b0; mC1 = 1'b0; mC0 = 1'b0;
  endtask

  // Offers one command, then scrambles the fields while still valid to prove they were latched.
  task automatic applyStimulus(input logic ld, input logic l, input logic [1:0] op,
                               input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic [3:0] imm);
    @(posedge clk); #1;
    cmdLd = ld; cmdL = l; cmdOp = op; cmdRd = rd; cmdRa = ra; cmdRb = rb; cmdImm = imm;
    dbgAddr = rd;
    cmdValid = 1'b1;
    checkOutput("ready_at_offer", cmdReady, 1);
    pushExpected(ld, l, op, rd, ra, rb, imm);
    @(posedge clk); #1;
    cmdLd = 1'($urandom); cmdL = 1'($urandom); cmdOp = 2'($urandom);
    cmdRd = 2'($urandom); cmdRa = 2'($urandom); cmdRb = 2'($urandom); cmdImm = 4'($urandom);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    for (int i = 0; i < 8 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain", sbQ.size(), 0);
    @(posedge clk);
  endtask

  // Pops on each done pulse; register/flag results are compared the cycle after writeback.
  always @(negedge clk) begin
    if (postPending) begin
      checkOutput("res", res, cur.res);
      checkOutput("flag_z", flagZ, cur.z);
      checkOutput("flag_s", flagS, cur.s);
      checkOutput("flag_c", flagC, cur.c1);
      checkOutput("keep_flag_c", kFlagC, cur.c0);
      checkOutput("dbg_post_wb", dbgData, cur.res);
      postPending = 0;
    end
    if (done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        cur = sbQ.pop_front();
        checkOutput("done_cycle", cyc, cur.expCyc);
        checkOutput("keep_done", kDone, 1);
        checkOutput("dbg_pre_wb", dbgData, cur.oldVal);
        if (cur.isAlu) begin
          checkOutput("alu_a", aluA, cur.a);
          checkOutput("alu_b", aluB, cur.b);
        end
        postPending = 1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", cmdReady, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_flags", {flagZ, flagC, flagS}, 0);
    checkOutput("rst_alu_a", aluA, 0);
    checkOutput("rst_alu_b", aluB, 0);
    checkOutput("rst_alu_ctl", {aluOp, aluL}, 0);
    for (int r = 0; r < 4; r++) begin
      dbgAddr = 2'(r);
      #1;
      checkOutput("rst_reg", dbgData, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", cmdReady, 1);

    // Loads, then 7 + 9 wraps to zero with carry.
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 4'd5);
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 4'd7);
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 4'd9);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 4'd0);
    // Logic AND with ALU carry high: one instance clears C, the other holds it.
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd2, 4'd0);
    // Fully aliased operands and destination.
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 4'd3);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 2'd2, 4'd0);
    applyStimulus(1'b0, 1'b1, 2'd3, 2'd3, 2'd1, 2'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd2, 4'd0);

    for (int n = 0; n < 8; n++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
                    2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
    end

    // cmd_valid held high: accepted only when the FSM is back in IDLE.
    dbgAddr = 2'd0;
    cmdLd = 1'b0; cmdL = 1'b0; cmdOp = 2'd0; cmdRd = 2'd0; cmdRa = 2'd0; cmdRb = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmdValid = 1'b1;
      checkOutput("hold_ready", cmdReady, (i % 4) == 0);
      if ((i % 4) == 0) pushExpected(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 4'd0);
    end
    @(posedge clk); #1;
    cmdValid = 1'b0;
    for (int i = 0; i < 8 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("hold_drain", sbQ.size(), 0);
    @(posedge clk);

    // Reset while in EXEC aborts the operation without writeback.
    @(posedge clk); #1;
    cmdLd = 1'b0; cmdL = 1'b0; cmdOp = 2'd0; cmdRd = 2'd3; cmdRa = 2'd1; cmdRb = 2'd1;
    dbgAddr = 2'd3;
    cmdValid = 1'b1;
    checkOutput("abort_ready", cmdReady, 1);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ready_in_rst", cmdReady, 0);
    checkOutput("abort_res", res, 0);
    checkOutput("abort_flags", {flagZ, flagC, flagS}, 0);
    checkOutput("abort_rd", dbgData, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    clearModel();
    @(negedge clk);
    checkOutput("abort_ready_after", cmdReady, 1);
    checkOutput("abort_rd_after", dbgData, 0);

    applyStimulus(1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 4'hA);

    checkOutput("queue_empty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: LOGIC_CLR_C, default 1, meaning: when 1, logic ops (l=1) write C flag 0; when 0, logic ops leave C unchanged.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_ld  input  1  1 = load immediate, 0 = ALU operation.
REQ-007 cmd_l  input  1  ALU unit select for the operation (0 arithmetic, 1 logic).
REQ-008 cmd_op  input  2  ALU opcode for the operation.
REQ-009 cmd_rd, cmd_ra, cmd_rb  input  2 each  destination, operand-A and operand-B register indices.
REQ-010 cmd_imm  input  4  immediate for loads.
REQ-011 alu_a, alu_b  output  4 each  registered operands driven to the ALU.
REQ-012 alu_op  output  2; alu_l  output  1  registered ALU controls.
REQ-013 alu_r  input  4; alu_zero, alu_carry, alu_sign  input  1 each  combinational ALU result and flags.
REQ-014 done  output  1  one-cycle pulse on writeback.
REQ-015 res  output  4  last value written to the register file.
REQ-016 flag_z, flag_c, flag_s  output  1 each  registered status flags.
REQ-017 dbg_addr  input  2; dbg_data  output  4  combinational register-file read port.

Function
REQ-018 The block SHALL hold a 4-entry x 4-bit register file, R0..R3, all writable.
REQ-019 The FSM SHALL have states IDLE, ISSUE, EXEC, WB.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid=1 and cmd_ready=1.
REQ-021 Command fields SHALL be latched on acceptance; later input changes SHALL NOT affect the operation.
REQ-022 Load accepted: IDLE->WB, then on the next edge write cmd_imm to rd; done=1 for one cycle, two cycles after acceptance; flags are unchanged.
REQ-023 ALU op accepted: IDLE->ISSUE; on entering ISSUE, alu_a=Rra, alu_b=Rrb, alu_op=cmd_op and alu_l=cmd_l are registered.
REQ-024 ISSUE->EXEC unconditionally; in EXEC, alu_r and the flags are sampled into internal result/flag registers on the EXEC->WB edge.
REQ-025 In WB, the sampled result SHALL be written to Rrd, res is updated, done=1, and the FSM returns to IDLE.
REQ-026 ALU op latency: done is asserted in the fourth cycle after acceptance; throughput is one command per 4 cycles, or per 2 cycles for loads.
REQ-027 flag_z/flag_s SHALL take alu_zero/alu_sign. flag_c SHALL take alu_carry when alu_l=0; when alu_l=1, it is written 0 if LOGIC_CLR_C=1 and held otherwise.
REQ-028 alu_a/alu_b/alu_op/alu_l SHALL hold their values outside ISSUE, so the ALU inputs are stable through EXEC.
REQ-029 ra, rb and rd may alias; operands are read before writeback, so Rx op Rx into Rx uses the old value.
REQ-030 dbg_data SHALL show the pre-write value during the WB cycle and the new value after the WB edge.
REQ-031 cmd_valid asserted while not IDLE SHALL be ignored; no command is queued.

Reset
REQ-032 While reset is asserted, the FSM SHALL be IDLE; R0..R3, alu_a, alu_b, alu_op, alu_l, res and all flags SHALL be 0; done SHALL be 0.
REQ-033 cmd_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-034 Reset mid-operation SHALL abort the operation with no writeback and no done pulse.

Verification
REQ-035 Load R1=5 -> done two cycles after acceptance; dbg_addr=1 reads 5; flags unchanged.
REQ-036 R1=7, R2=9, arithmetic op with ALU returning r=0 and carry=1 into R3 -> done in cycle 4; R3=0, flag_z=1, flag_c=1, flag_s=0.
REQ-037 Logic op with ALU carry=1 and LOGIC_CLR_C=1 -> flag_c=0; repeat with LOGIC_CLR_C=0 -> flag_c keeps its prior value.
REQ-038 cmd_valid held high for 10 cycles -> exactly one ALU command accepted per 4 cycles; cmd_ready is low in ISSUE, EXEC and WB.
REQ-039 Reset asserted in EXEC -> no done pulse; Rrd, res and flags are 0; cmd_ready=1 one cycle after deassertion.
REQ-040 R2=3, op R2,R2->R2 -> ALU sees alu_a=alu_b=3; dbg_data for R2 reads 3 in the WB cycle and the result after it.
